// File: rtl/wb_master_engine.sv
// wb_master_engine
//   Single-outstanding Wishbone classic master. Accepts one command on a
//   valid/ready stream, runs it as a bus cycle, and returns one response.
//   Handles ack/err/rty termination, a per-attempt timeout and bounded retry.
//
// Ports
//   wb_clk_i, wb_rst_ni        clock, async active-low reset
//   cmd_valid_i/cmd_ready_o    command handshake; cmd_we/adr/dat/sel payload
//   rsp_valid_o/rsp_ready_i    response handshake; rsp_dat_o, rsp_status_o
//                              (00 OK, 01 ERR, 10 TIMEOUT, 11 RETRY_EXHAUSTED)
//   wbm_*                      Wishbone master side
//   busy_o                     high whenever a command is in flight
module wb_master_engine #(
    parameter int TIMEOUT_CYCLES = 255,  // 0 disables the timeout
    parameter int MAX_RETRIES    = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic [1:0]  rsp_status_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i,
    output logic        busy_o
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TW-1:0] TO_LAST = TO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [RW-1:0] RTY_MAX = RW'(MAX_RETRIES);

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;
    localparam logic [1:0] ST_RTX = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_BACKOFF, S_RESP} state_t;

    state_t        state;
    logic [TW-1:0] to_cnt;
    logic [RW-1:0] retry_cnt;

    logic tmo, retry_ok, bus_done;

    assign tmo      = TO_EN && (to_cnt == TO_LAST);
    assign retry_ok = (retry_cnt < RTY_MAX);
    // A retryable rty outranks the timeout, so a timeout only ends the
    // attempt when no rty is present on that edge.
    assign bus_done = wbm_ack_i || wbm_err_i || (wbm_rty_i && !retry_ok) ||
                      (!wbm_rty_i && tmo);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state        <= S_IDLE;
            to_cnt       <= '0;
            retry_cnt    <= '0;
            cmd_ready_o  <= 1'b1;
            rsp_valid_o  <= 1'b0;
            rsp_dat_o    <= '0;
            rsp_status_o <= ST_OK;
            wbm_adr_o    <= '0;
            wbm_dat_o    <= '0;
            wbm_sel_o    <= '0;
            wbm_we_o     <= 1'b0;
            wbm_cyc_o    <= 1'b0;
            wbm_stb_o    <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        // The bus outputs double as the latched command.
                        wbm_adr_o   <= cmd_adr_i;
                        wbm_dat_o   <= cmd_dat_i;
                        wbm_sel_o   <= cmd_sel_i;
                        wbm_we_o    <= cmd_we_i;
                        wbm_cyc_o   <= 1'b1;
                        wbm_stb_o   <= 1'b1;
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        retry_cnt   <= '0;
                        to_cnt      <= '0;
                        state       <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (bus_done) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_dat_o   <= (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : '0;
                        if (wbm_ack_i)      rsp_status_o <= ST_OK;
                        else if (wbm_err_i) rsp_status_o <= ST_ERR;
                        else if (wbm_rty_i) rsp_status_o <= ST_RTX;
                        else                rsp_status_o <= ST_TMO;
                        state <= S_RESP;
                    end else if (wbm_rty_i) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        to_cnt    <= '0;
                        state     <= S_BACKOFF;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_BACKOFF: begin
                    // One idle cycle, then re-issue the same latched command.
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                    to_cnt    <= '0;
                    state     <= S_BUS;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_engine.sv
// Bench for wb_master_engine. The main instance uses TIMEOUT_CYCLES=8,
// MAX_RETRIES=3; a second instance with the timeout disabled shares all
// inputs and is only examined in the final long-wait scenario (after a reset
// realigns both). The slave is scripted per attempt (wait states, termination
// mix, read data) and expected results come from an attempt-level model.
module tb_wb_master_engine;
    localparam int TO = 8;
    localparam int MR = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0, cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_ready = 1'b1;
    logic [31:0] wb_din = '0;
    logic        ack = 1'b0, err = 1'b0, rty = 1'b0;

    logic        cmd_ready, rsp_valid, we_o, cyc, stb, busy;
    logic [31:0] rsp_dat, adr_o, dat_o;
    logic [1:0]  status;
    logic [3:0]  sel_o;

    logic        n_cmd_ready, n_rsp_valid, n_we_o, n_cyc, n_stb, n_busy;
    logic [31:0] n_rsp_dat, n_adr_o, n_dat_o;
    logic [1:0]  n_status;
    logic [3:0]  n_sel_o;

    always #5 clk = ~clk;

    wb_master_engine #(.TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
        .rsp_status_o(status), .wbm_adr_o(adr_o), .wbm_dat_o(dat_o),
        .wbm_sel_o(sel_o), .wbm_we_o(we_o), .wbm_cyc_o(cyc), .wbm_stb_o(stb),
        .wbm_dat_i(wb_din), .wbm_ack_i(ack), .wbm_err_i(err), .wbm_rty_i(rty),
        .busy_o(busy)
    );

    wb_master_engine #(.TIMEOUT_CYCLES(0), .MAX_RETRIES(MR)) dut_nt (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(n_cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(n_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(n_rsp_dat),
        .rsp_status_o(n_status), .wbm_adr_o(n_adr_o), .wbm_dat_o(n_dat_o),
        .wbm_sel_o(n_sel_o), .wbm_we_o(n_we_o), .wbm_cyc_o(n_cyc), .wbm_stb_o(n_stb),
        .wbm_dat_i(wb_din), .wbm_ack_i(ack), .wbm_err_i(err), .wbm_rty_i(rty),
        .busy_o(n_busy)
    );

    int passed = 0;
    int total  = 0;

    // Slave script per attempt: wait states, termination bits (1 ack, 2 err,
    // 4 rty, 0 never terminates), and read data presented with the termination.
    int          plan_wait [8];
    int          plan_term [8];
    logic [31:0] plan_rdat [8];
    int          e_len     [8];
    int          tlist     [7] = '{1, 2, 4, 3, 6, 5, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic plan(input int a, input int w, input int t, input logic [31:0] d);
        plan_wait[a] = w;
        plan_term[a] = t;
        plan_rdat[a] = d;
    endtask

    // Walk the attempts: each either times out, terminates, or retries.
    task automatic model(input logic we, output logic [1:0] st, output logic [31:0] d,
                         output int natt);
        st = 2'b00; d = '0; natt = 0;
        for (int a = 0; a <= MR; a++) begin
            natt = a + 1;
            if (plan_term[a] == 0 || plan_wait[a] >= TO) begin
                e_len[a] = TO; st = 2'b10; return;
            end
            e_len[a] = plan_wait[a] + 1;
            if ((plan_term[a] & 1) != 0) begin
                st = 2'b00; d = we ? 32'h0 : plan_rdat[a]; return;
            end
            if ((plan_term[a] & 2) != 0) begin st = 2'b01; return; end
            if (a == MR) begin st = 2'b11; return; end
        end
    endtask

    task automatic run_cmd(input string tag, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel, input int hold);
        logic [1:0]  e_st, st;
        logic [31:0] e_d, rd;
        int e_att, e_lat;
        int lat = 0, att = 0, len_cnt = 0, gap = 0;
        int bus_bad = 0, len_bad = 0, gap_bad = 0, hold_bad = 0;
        bit got = 1'b0;
        model(we, e_st, e_d, e_att);
        e_lat = e_att;  // (attempts-1) backoff cycles + 1 cycle to see rsp_valid
        for (int a = 0; a < e_att; a++) e_lat += e_len[a];

        @(negedge clk);
        check({tag, "/cmd_ready"}, cmd_ready, 1);
        rsp_ready = (hold == 0);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        @(posedge clk);
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            lat++;
            if (hold == 0) cmd_valid = 1'b0;
            ack = 1'b0; err = 1'b0; rty = 1'b0; wb_din = $urandom;
            if (rsp_valid) begin
                got = 1'b1;
            end else if (stb) begin
                if (!cyc || adr_o !== adr || dat_o !== dat || sel_o !== sel ||
                    we_o !== we || cmd_ready !== 1'b0 || busy !== 1'b1) bus_bad++;
                if (len_cnt == 0 && att > 0 && gap != 1) gap_bad++;
                len_cnt++;
                if (att < 8 && len_cnt == plan_wait[att] + 1) begin
                    ack    = (plan_term[att] & 1) != 0;
                    err    = (plan_term[att] & 2) != 0;
                    rty    = (plan_term[att] & 4) != 0;
                    wb_din = plan_rdat[att];
                end
            end else begin
                if (len_cnt > 0) begin
                    if (att >= 8 || len_cnt != e_len[att]) len_bad++;
                    att++; len_cnt = 0; gap = 0;
                end
                if (cyc) bus_bad++;
                gap++;
                // Terminations with stb low must be ignored.
                ack = 1'($urandom_range(0, 1));
                err = 1'($urandom_range(0, 1));
                rty = 1'($urandom_range(0, 1));
            end
        end
        if (len_cnt > 0) begin
            if (att >= 8 || len_cnt != e_len[att]) len_bad++;
            att++;
        end
        check({tag, "/rsp_seen"}, got, 1);
        check({tag, "/latency"}, lat, e_lat);
        check({tag, "/attempts"}, att, e_att);
        check({tag, "/attempt_len"}, len_bad, 0);
        check({tag, "/backoff_gap"}, gap_bad, 0);
        check({tag, "/bus_fields"}, bus_bad, 0);
        check({tag, "/status"}, status, e_st);
        check({tag, "/rsp_dat"}, rsp_dat, e_d);
        check({tag, "/busy_resp"}, busy, 1);

        rd = rsp_dat; st = status;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_dat !== rd || status !== st)
                hold_bad++;
        end
        if (hold > 0) check({tag, "/hold_stable"}, hold_bad, 0);
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check({tag, "/consumed"}, {rsp_valid, cmd_ready, busy, stb}, 4'b0100);
    endtask

    initial begin
        int to_stb, nt_stb;
        logic [2:0] snap;

        // Reset values, checked while reset is held.
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst/cmd_ready", cmd_ready, 1);
        check("rst/rsp_valid", rsp_valid, 0);
        check("rst/status", status, 0);
        check("rst/rsp_dat", rsp_dat, 0);
        check("rst/ctl", {cyc, stb, we_o, busy}, 0);
        check("rst/adr", adr_o, 0);
        check("rst/dat", dat_o, 0);
        check("rst/sel", sel_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait write.
        plan(0, 0, 1, 32'h1111_1111);
        run_cmd("wr0", 1'b1, 32'h3080_0000, 32'hDEAD_BEEF, 4'hF, 0);
        // Read with three wait states.
        plan(0, 3, 1, 32'h0000_1234);
        run_cmd("rd3", 1'b0, 32'h3082_0004, 32'h0, 4'hF, 0);
        // rty on every attempt.
        for (int a = 0; a < 4; a++) plan(a, a & 1, 4, 32'hAAAA_0000 + a);
        run_cmd("rtyx", 1'b0, 32'h3081_0000, 32'h0, 4'h3, 0);
        // rty once, then a successful read.
        plan(0, 1, 4, 32'h0); plan(1, 2, 1, 32'h5A5A_0001);
        run_cmd("rty_ok", 1'b0, 32'h3081_0010, 32'h0, 4'hF, 0);
        // ack+err together resolves to ack.
        plan(0, 1, 3, 32'hC0DE_0002);
        run_cmd("ack_err", 1'b0, 32'h3080_0020, 32'h0, 4'h1, 0);
        // err+rty together resolves to err, no retry.
        plan(0, 0, 6, 32'h0); plan(1, 0, 1, 32'h0);
        run_cmd("err_rty", 1'b1, 32'h3080_0030, 32'h1234_5678, 4'hC, 0);
        // Back-pressure on the response while a new command waits.
        plan(0, 2, 1, 32'h7777_0003);
        run_cmd("hold5", 1'b0, 32'h3083_0000, 32'h0, 4'hF, 5);

        // Randomized slave behaviour and commands.
        for (int i = 0; i < 16; i++) begin
            for (int a = 0; a < 4; a++)
                plan(a, $urandom_range(0, 9), tlist[$urandom_range(0, 6)], $urandom);
            run_cmd($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), $urandom, $urandom,
                    4'($urandom_range(0, 15)), $urandom_range(0, 2));
        end

        // Reset asserted in the middle of a bus cycle.
        for (int a = 0; a < 4; a++) plan(a, 0, 0, 32'h0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3084_0000; rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("midrst/stb_before", stb, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst/async", {cyc, stb, rsp_valid, cmd_ready, busy}, 5'b00010);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst/after", {cmd_ready, stb, rsp_valid}, 3'b100);

        // Silent slave: the timeout instance gives up after 8 cycles, the
        // no-timeout instance waits until the slave acks in its 300th cycle.
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3081_0008; cmd_sel = 4'hF;
        check("to/ready_both", {cmd_ready, n_cmd_ready}, 2'b11);
        @(posedge clk);
        to_stb = 0; nt_stb = 0; snap = '0;
        for (int c = 1; c <= 305; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            ack = 1'b0; err = 1'b0; rty = 1'b0; wb_din = $urandom;
            if (stb) to_stb++;
            if (n_stb) nt_stb++;
            if (c == 9) snap = {stb, cyc, rsp_valid};
            if (c == 300 && n_stb) begin
                ack = 1'b1; wb_din = 32'h0000_BEEF;
            end
        end
        check("to/stb_cycles", to_stb, TO);
        check("to/drop_edge", snap, 3'b001);
        check("to/status", status, 2'b10);
        check("to/rsp_dat", rsp_dat, 0);
        check("to/rsp_valid_held", rsp_valid, 1);
        check("nt/stb_cycles", nt_stb, 300);
        check("nt/rsp_valid", n_rsp_valid, 1);
        check("nt/status", n_status, 2'b00);
        check("nt/rsp_dat", n_rsp_dat, 32'h0000_BEEF);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("to/consumed", {rsp_valid, cmd_ready, n_rsp_valid, n_cmd_ready}, 4'b0101);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
